seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, multi-cycle successor to the datapath ALU. Single-cycle ops (add/sub/or/and/slt/pass) return one cycle after issue. Iterative unsigned multiply and divide take WIDTH+1 cycles. Operands and results move through valid/ready handshakes, so the control FSM stalls on long ops instead of assuming combinational completion.

## Interface
- WIDTH, 32: operand/result width (≥4).
- OP_W, 4: opcode width, fixed at 4; exposed for package consistency.
- clk  input  1: rising-edge clock.
- rst_n  input  1: reset, asynchronous, active-low.
- in_valid  input  1: operands and opcode valid.
- in_ready  output  1: block can accept; high only in IDLE.
- A  input  WIDTH: first operand.
- B  input  WIDTH: second operand.
- ALUctrl  input  OP_W: opcode.
- out_valid  output  1: result valid; held until accepted.
- out_ready  input  1: consumer accepts result.
- ALU  output  WIDTH: registered result.
- zero  output  1: ALU == 0.
- carrier  output  1: bit WIDTH of the sign-extended (WIDTH+1)-bit add/sub; 0 for other ops.
- dbz  output  1: divide by zero on divu/remu; 0 otherwise.

## Operation
- Opcodes (4 bit):
  - 0001/0110/0111 add.
  - 0011/0101 sub.
  - 0010 or.
  - 1000 and.
  - 1001 slt (signed, result 0 or 1).
  - 1100 mul (low WIDTH bits).
  - 1101 mulhu (high WIDTH bits).
  - 1110 divu.
  - 1111 remu.
  - All others pass B.
- Add/sub: ({A[msb],A} ± {B[msb],B}); ALU = low WIDTH bits, carrier = bit WIDTH.
- Accept occurs on in_valid && in_ready. A, B and ALUctrl are captured; later input changes are ignored.
- FSM states and transitions:
  - IDLE → DONE for single-cycle ops.
  - IDLE → MUL for 1100/1101.
  - IDLE → DIV for 1110/1111.
  - MUL/DIV → DONE after WIDTH iterations.
  - DONE → IDLE on out_ready.
- MUL: shift-add, one multiplier bit per cycle, 2·WIDTH-bit accumulator.
- DIV: restoring, one quotient bit per cycle.
- Divide by zero: quotient = all ones, remainder = A, dbz = 1. Same latency as a normal divide.
- Flags: zero, carrier and dbz are registered with ALU and stay stable while out_valid is high.

## Timing
- Reset: all outputs 0, including in_ready. Next cycle: in_ready = 1, state = IDLE.
- Single-cycle op accepted at cycle t: out_valid at t+1.
- Mul/div accepted at cycle t: out_valid at t+WIDTH+1.
- Handshake at DONE: out_valid && out_ready at cycle u gives out_valid = 0 and in_ready = 1 at u+1. There is no same-cycle bypass, so peak throughput is one op per 2 cycles.
- out_ready held high earlier has no effect until out_valid rises.
- in_valid outside IDLE is ignored; the producer must hold it until in_ready.
- rst_n low at any point, including mid-MUL/DIV: immediate return to reset values. The partial result is discarded and never emitted.

## Configuration
- SEQ_ALU_MULDIV_EN:
  - Defined: MUL/DIV states, the iterative unit and dbz are present.
  - Undefined: opcodes 1100–1111 take the pass-B path with single-cycle latency, dbz is tied to 0, and the FSM has only IDLE/DONE.

## Structure
- Package seq_alu_pkg holds:
  - Opcode localparams (OP_ADD, OP_SUB, OP_OR, OP_LW, OP_SW, OP_BEQ, OP_AND, OP_SLT, OP_MUL, OP_MULHU, OP_DIVU, OP_REMU).
  - FSM state enum (IDLE, MUL, DIV, DONE).
- Sub-module seq_alu_muldiv:
  - Contains the iterative shift-add/restoring unit with start/busy/done, iteration counter and accumulator.
  - Instantiated only under SEQ_ALU_MULDIV_EN.

## Test plan
- add A=0x7FFFFFFF, B=1 → ALU=0x80000000, carrier=0, zero=0, out_valid 1 cycle after accept.
- sub 5−5 → ALU=0, zero=1; sub 0−1 → ALU=0xFFFFFFFF, carrier=1.
- mul/mulhu A=0xFFFFFFFF, B=2 → ALU=0xFFFFFFFE / 0x00000001; out_valid exactly 33 cycles after accept; in_ready low throughout.
- divu/remu A=100, B=7 → 14 / 2. divu 9/0 → 0xFFFFFFFF, dbz=1. remu 9/0 → 9, dbz=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → ALU and flags stable, new in_valid ignored. Accept → in_ready=1 the next cycle.
- rst_n pulsed low 10 cycles into a mul → outputs 0 immediately. Next op, add 3+4 → 7, with no stale result emitted.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM state type and opcode-class helpers for seq_alu.
`timescale 1ns/1ps
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_OR    = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0101;
    localparam logic [3:0] OP_LW    = 4'b0110;
    localparam logic [3:0] OP_SW    = 4'b0111;
    localparam logic [3:0] OP_AND   = 4'b1000;
    localparam logic [3:0] OP_SLT   = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1100;
    localparam logic [3:0] OP_MULHU = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1110;
    localparam logic [3:0] OP_REMU  = 4'b1111;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    function automatic logic is_long_op(input logic [3:0] op);
        return op inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return op inside {OP_DIVU, OP_REMU};
    endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// Only present when SEQ_ALU_MULDIV_EN is defined.
`timescale 1ns/1ps
`ifdef SEQ_ALU_MULDIV_EN
module seq_alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);
    localparam int CNT_W = $clog2(WIDTH);

    logic               busy;
    logic               div_mode;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_part;
    logic [WIDTH:0]     div_diff;

    // Multiply keeps {partial, multiplier}; divide keeps {remainder, dividend/quotient}.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_part = acc[2*WIDTH-1:WIDTH-1];
        div_diff = div_part - {1'b0, opnd};
        if (!div_mode)
            acc_nxt = {mul_sum, acc[WIDTH-1:1]};
        else if (div_part >= {1'b0, opnd})
            acc_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            acc_nxt = {div_part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            div_mode <= 1'b0;
            cnt      <= '0;
            opnd     <= '0;
            acc      <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            div_mode <= is_div;
            cnt      <= '0;
            opnd     <= is_div ? b : a;
            acc      <= {{WIDTH{1'b0}}, (is_div ? a : b)};
        end else if (busy) begin
            acc <= acc_nxt;
            cnt <= cnt + CNT_W'(1);
            if (done)
                busy <= 1'b0;
        end
    end

    // The final step's result is handed out combinationally so the top can register it on the same edge.
    assign done = busy && (cnt == CNT_W'(WIDTH - 1));
    assign lo   = acc_nxt[WIDTH-1:0];
    assign hi   = acc_nxt[2*WIDTH-1:WIDTH];

endmodule
`endif

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes on operands and result.
// Define SEQ_ALU_MULDIV_EN to add iterative mul/mulhu/divu/remu and the dbz flag.
`timescale 1ns/1ps
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [OP_W-1:0]  ALUctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU,
    output logic             zero,
    output logic             carrier,
    output logic             dbz
);
    state_t           state;
    logic             accept;
    logic             finish;
    logic             sc_carry;
    logic             fin_carry;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] sc_res;
    logic [WIDTH-1:0] fin_res;

    assign accept = in_valid && in_ready;

    always_comb begin
        sum_ext  = '0;
        sc_res   = B;
        sc_carry = 1'b0;
        case (ALUctrl)
            OP_ADD, OP_LW, OP_SW: begin
                sum_ext  = {A[WIDTH-1], A} + {B[WIDTH-1], B};
                sc_res   = sum_ext[WIDTH-1:0];
                sc_carry = sum_ext[WIDTH];
            end
            OP_SUB, OP_BEQ: begin
                sum_ext  = {A[WIDTH-1], A} - {B[WIDTH-1], B};
                sc_res   = sum_ext[WIDTH-1:0];
                sc_carry = sum_ext[WIDTH];
            end
            OP_OR:   sc_res = A | B;
            OP_AND:  sc_res = A & B;
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            default: sc_res = B;
        endcase
    end

`ifdef SEQ_ALU_MULDIV_EN
    logic             is_long;
    logic             sel_hi;
    logic             b_zero;
    logic             dbz_q;
    logic             md_done;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;

    assign is_long = is_long_op(ALUctrl);

    seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && is_long),
        .is_div (is_div_op(ALUctrl)),
        .a      (A),
        .b      (B),
        .done   (md_done),
        .lo     (md_lo),
        .hi     (md_hi)
    );

    // Opcode bit 0 picks the high half for mulhu and the remainder for remu.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_hi <= 1'b0;
            b_zero <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            if (accept) begin
                sel_hi <= ALUctrl[0];
                b_zero <= (B == '0);
            end
            if (finish)
                dbz_q <= (state == DIV) && b_zero;
        end
    end

    assign dbz = dbz_q;
`else
    assign dbz = 1'b0;
`endif

    always_comb begin
        finish    = 1'b0;
        fin_res   = sc_res;
        fin_carry = sc_carry;
        case (state)
`ifdef SEQ_ALU_MULDIV_EN
            IDLE: finish = accept && !is_long;
            MUL, DIV: begin
                finish    = md_done;
                fin_res   = sel_hi ? md_hi : md_lo;
                fin_carry = 1'b0;
            end
`else
            IDLE: finish = accept;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            ALU       <= '0;
            zero      <= 1'b0;
            carrier   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= !accept;
`ifdef SEQ_ALU_MULDIV_EN
                    if (accept && is_long)
                        state <= is_div_op(ALUctrl) ? DIV : MUL;
`endif
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: ;
            endcase
            if (finish) begin
                state     <= DONE;
                out_valid <= 1'b1;
                ALU       <= fin_res;
                zero      <= (fin_res == '0);
                carrier   <= fin_carry;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed test-plan vectors plus randomized ops
// against an arithmetic reference model; follows SEQ_ALU_MULDIV_EN like the RTL.
`timescale 1ns/1ps
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [3:0]   ALUctrl;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] ALU;
    logic         zero;
    logic         carrier;
    logic         dbz;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(W), .OP_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .ALUctrl   (ALUctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALU       (ALU),
        .zero      (zero),
        .carrier   (carrier),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain signed/unsigned arithmetic on wide integers.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic c, output logic d, output int lat);
        longint      sa;
        longint      sb;
        longint      s;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        s   = 0;
        p   = '0;
        c   = 1'b0;
        d   = 1'b0;
        lat = 1;
        case (op)
            4'd1, 4'd6, 4'd7: begin s = sa + sb; r = s[31:0]; c = s[32]; end
            4'd3, 4'd5:       begin s = sa - sb; r = s[31:0]; c = s[32]; end
            4'd2:             r = a | b;
            4'd8:             r = a & b;
            4'd9:             r = (sa < sb) ? 32'd1 : 32'd0;
`ifdef SEQ_ALU_MULDIV_EN
            4'd12: begin p = 64'(a) * 64'(b); r = p[31:0];  lat = W + 1; end
            4'd13: begin p = 64'(a) * 64'(b); r = p[63:32]; lat = W + 1; end
            4'd14: begin r = (b == 0) ? 32'hFFFF_FFFF : a / b; d = (b == 0); lat = W + 1; end
            4'd15: begin r = (b == 0) ? a : a % b;             d = (b == 0); lat = W + 1; end
`endif
            default:          r = b;
        endcase
    endfunction

    // Issues one op, scrambles the inputs after accept, and waits (bounded) for out_valid.
    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic z, output logic c, output logic d,
                         output int lat, output logic leak);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        ALUctrl  = op;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ALUctrl  = 4'($urandom_range(15, 0));
        A        = $urandom;
        B        = $urandom;
        lat      = 1;
        leak     = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) leak = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready) leak = 1'b1;
        r = ALU;
        z = zero;
        c = carrier;
        d = dbz;
    endtask

    task automatic do_release(output logic ov, output logic ir);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        ov = out_valid;
        ir = in_ready;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        ALUctrl   = '0;
        #12;
        checks++;
        if ({in_ready, out_valid, zero, carrier, dbz} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 00000", {in_ready, out_valid, zero, carrier, dbz});
        end
        checks++;
        if (ALU !== '0) begin
            errors++;
            $display("[TB] FAIL reset_alu: got %h expected 0", ALU);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    logic [3:0]   dir_op [6] = '{OP_ADD, OP_SUB, OP_SUB, OP_AND, OP_SLT, OP_SLT};
    logic [W-1:0] dir_a  [6] = '{32'h7FFF_FFFF, 32'd5, 32'd0, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'd1};
    logic [W-1:0] dir_b  [6] = '{32'd1, 32'd5, 32'd1, 32'h0FF0_0FF0, 32'd1, 32'hFFFF_FFFF};
    logic [W-1:0] dir_r  [6] = '{32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'h00F0_00F0, 32'd1, 32'd0};
    logic         dir_c  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    task automatic test_single_cycle();
        logic [W-1:0] r;
        logic         z, c, d, leak, ov, ir;
        int           lat;
        for (int i = 0; i < 6; i++) begin
            do_op(dir_op[i], dir_a[i], dir_b[i], r, z, c, d, lat, leak);
            checks++;
            if (r !== dir_r[i] || c !== dir_c[i] || z !== (dir_r[i] == 0)) begin
                errors++;
                $display("[TB] FAIL single_%0d: got ALU=%h c=%b z=%b expected ALU=%h c=%b z=%b",
                         i, r, c, z, dir_r[i], dir_c[i], (dir_r[i] == 0));
            end
            checks++;
            if (lat !== 1 || leak !== 1'b0) begin
                errors++;
                $display("[TB] FAIL single_lat_%0d: got latency=%0d in_ready_leak=%b expected 1/0", i, lat, leak);
            end
            do_release(ov, ir);
            checks++;
            if (ov !== 1'b0 || ir !== 1'b1) begin
                errors++;
                $display("[TB] FAIL single_release_%0d: out_valid=%b in_ready=%b expected 0/1", i, ov, ir);
            end
        end
    endtask

`ifdef SEQ_ALU_MULDIV_EN
    logic [3:0]   md_op [6] = '{OP_MUL, OP_MULHU, OP_DIVU, OP_REMU, OP_DIVU, OP_REMU};
    logic [W-1:0] md_a  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100, 32'd9, 32'd9};
    logic [W-1:0] md_b  [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0};
    logic [W-1:0] md_r  [6] = '{32'hFFFF_FFFE, 32'd1, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd9};
    logic         md_d  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    task automatic test_muldiv();
        logic [W-1:0] r;
        logic         z, c, d, leak, ov, ir;
        int           lat;
        for (int i = 0; i < 6; i++) begin
            do_op(md_op[i], md_a[i], md_b[i], r, z, c, d, lat, leak);
            checks++;
            if (r !== md_r[i] || d !== md_d[i] || c !== 1'b0) begin
                errors++;
                $display("[TB] FAIL muldiv_%0d: got ALU=%h dbz=%b c=%b expected ALU=%h dbz=%b c=0",
                         i, r, d, c, md_r[i], md_d[i]);
            end
            checks++;
            if (lat !== W + 1 || leak !== 1'b0) begin
                errors++;
                $display("[TB] FAIL muldiv_lat_%0d: got latency=%0d in_ready_leak=%b expected %0d/0", i, lat, leak, W + 1);
            end
            do_release(ov, ir);
        end
    endtask
`else
    task automatic test_passb();
        logic [W-1:0] r, b;
        logic         z, c, d, leak, ov, ir;
        int           lat;
        for (int i = 12; i < 16; i++) begin
            b = $urandom;
            do_op(4'(i), 32'd9, b, r, z, c, d, lat, leak);
            checks++;
            if (r !== b || d !== 1'b0 || c !== 1'b0 || lat !== 1) begin
                errors++;
                $display("[TB] FAIL passb_%0d: got ALU=%h dbz=%b c=%b lat=%0d expected ALU=%h dbz=0 c=0 lat=1",
                         i, r, d, c, lat, b);
            end
            do_release(ov, ir);
        end
    endtask
`endif

    task automatic test_backpressure();
        logic [W-1:0] a, b, r, er;
        logic         z, c, d, leak, ec, ed;
        int           lat, el;
        a = $urandom;
        b = $urandom;
        model(OP_SUB, a, b, er, ec, ed, el);
        do_op(OP_SUB, a, b, r, z, c, d, lat, leak);
        checks++;
        if (r !== er || c !== ec) begin
            errors++;
            $display("[TB] FAIL bp_result: got ALU=%h c=%b expected ALU=%h c=%b", r, c, er, ec);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            ALUctrl  = OP_ADD;
            A        = $urandom;
            B        = $urandom;
            @(posedge clk); #1;
            checks++;
            if (ALU !== er || carrier !== ec || zero !== (er == 0) || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold_%0d: ALU=%h c=%b ov=%b ir=%b expected ALU=%h c=%b ov=1 ir=0",
                         i, ALU, carrier, out_valid, in_ready, er, ec);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_accept: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_ignored_input: out_valid=%b expected 0", out_valid);
        end
    endtask

    // out_ready held high throughout: each op should drain one cycle after out_valid rises.
    task automatic test_back_to_back();
        logic [3:0]   op;
        logic [W-1:0] a, b, r, er;
        logic         z, c, d, leak, ec, ed;
        int           lat, el;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            op = 4'($urandom_range(15, 0));
            a  = $urandom;
            b  = $urandom;
            model(op, a, b, er, ec, ed, el);
            do_op(op, a, b, r, z, c, d, lat, leak);
            checks++;
            if (r !== er || c !== ec || d !== ed || lat !== el) begin
                errors++;
                $display("[TB] FAIL b2b_%0d op=%h: got ALU=%h c=%b dbz=%b lat=%0d expected ALU=%h c=%b dbz=%b lat=%0d",
                         i, op, r, c, d, lat, er, ec, ed, el);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_drain_%0d: out_valid=%b in_ready=%b expected 0/1", i, out_valid, in_ready);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        logic [W-1:0] r;
        logic         z, c, d, leak, ov, ir, seen;
        int           lat, n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        ALUctrl  = OP_MUL;
        A        = 32'hFFFF_FFFF;
        B        = 32'd2;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, zero, carrier, dbz} !== 5'b0 || ALU !== '0) begin
            errors++;
            $display("[TB] FAIL midop_reset: flags=%b ALU=%h expected 00000/0",
                     {in_ready, out_valid, zero, carrier, dbz}, ALU);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midop_stale: out_valid seen=%b expected 0", seen);
        end
        do_op(OP_ADD, 32'd3, 32'd4, r, z, c, d, lat, leak);
        checks++;
        if (r !== 32'd7 || lat !== 1 || z !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midop_next: got ALU=%h lat=%0d z=%b expected ALU=7 lat=1 z=0", r, lat, z);
        end
        do_release(ov, ir);
    endtask

    task automatic test_random();
        logic [3:0]   op;
        logic [W-1:0] a, b, r, er;
        logic         z, c, d, leak, ec, ed, ov, ir;
        int           lat, el;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(15, 0));
            a  = $urandom;
            b  = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(3, 0)) : $urandom;
            model(op, a, b, er, ec, ed, el);
            do_op(op, a, b, r, z, c, d, lat, leak);
            checks++;
            if (r !== er || z !== (er == 0) || c !== ec || d !== ed) begin
                errors++;
                $display("[TB] FAIL rand_%0d op=%h a=%h b=%h: got ALU=%h z=%b c=%b dbz=%b expected ALU=%h z=%b c=%b dbz=%b",
                         i, op, a, b, r, z, c, d, er, (er == 0), ec, ed);
            end
            checks++;
            if (lat !== el || leak !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rand_lat_%0d op=%h: got latency=%0d leak=%b expected %0d/0", i, op, lat, leak, el);
            end
            do_release(ov, ir);
            checks++;
            if (ov !== 1'b0 || ir !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rand_release_%0d: out_valid=%b in_ready=%b expected 0/1", i, ov, ir);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
`ifdef SEQ_ALU_MULDIV_EN
        test_muldiv();
`else
        test_passb();
`endif
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
